// File: rtl/kyber_pkg.sv
// Shared ML-KEM constants, GenMatrix controller state encoding and XOF seed packing.
package kyber_pkg;

    localparam int unsigned Q     = 3329;
    localparam int unsigned N     = 256;
    localparam int unsigned K_MAX = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_WAIT_SN,
        S_DONE
    } gen_state_t;

    // Byte b of the seed sits at [8b+:8]: rho in bytes 0..31, then b32, then b33.
    function automatic logic [271:0] build_xof_seed(input logic [255:0] rho,
                                                    input logic [7:0]   b32,
                                                    input logic [7:0]   b33);
        return {b33, b32, rho};
    endfunction

endpackage

// File: rtl/matrix_gen_ctrl.sv
// GenMatrix sequencer: runs SHAKE128 + SampleNTT once per (i,j) of the k x k matrix A-hat
// and streams each polynomial's coefficients into the polynomial RAM.
module matrix_gen_ctrl #(
    parameter int unsigned K_MAX  = kyber_pkg::K_MAX,
    parameter int unsigned IDX_W  = $clog2(K_MAX * K_MAX),
    parameter int unsigned ADDR_W = IDX_W + 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        k_i,
    input  logic              transpose_i,
    input  logic [255:0]      rho_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic              xof_ready_i,
    output logic              xof_start_o,
    output logic [271:0]      xof_seed_o,
    output logic              xof_stop_o,
    output logic              sn_start_o,
    input  logic              sn_done_i,
    input  logic [15:0]       s_data_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [11:0]       mem_wdata_o,
    input  logic              mem_ready_i
);
    import kyber_pkg::*;

    gen_state_t   state_q, state_d;
    logic [1:0]   i_q, i_d, j_q, j_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [2:0]   k_q, k_d;
    logic         tr_q, tr_d;
    logic [255:0] rho_q, rho_d;
    logic         err_q, err_d;

    logic       k_ok, j_last, i_last, cnt_full, hs;
    logic [7:0] b32, b33;
    logic       unused_data;

    assign k_ok        = (k_i >= 3'd2) && (k_i <= 3'd4);
    assign j_last      = ({1'b0, j_q} == (k_q - 3'd1));
    assign i_last      = ({1'b0, i_q} == (k_q - 3'd1));
    assign cnt_full    = (cnt_q == 8'(N - 1));
    assign unused_data = ^s_data_i[15:12];

    // Transposed generation swaps which index lands in byte 32; the RAM layout does not change.
    assign b32 = tr_q ? {6'd0, i_q} : {6'd0, j_q};
    assign b33 = tr_q ? {6'd0, j_q} : {6'd0, i_q};

    assign xof_seed_o = build_xof_seed(rho_q, b32, b33);
    assign mem_addr_o = {IDX_W'(i_q * K_MAX + j_q), cnt_q};
    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;
    assign hs         = (state_q == S_RUN) && s_valid_i && mem_ready_i;

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        tr_d        = tr_q;
        rho_d       = rho_q;
        err_d       = err_q;
        done_o      = 1'b0;
        xof_start_o = 1'b0;
        xof_stop_o  = 1'b0;
        sn_start_o  = 1'b0;
        s_ready_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = 12'd0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    k_d   = k_i;
                    tr_d  = transpose_i;
                    rho_d = rho_i;
                    err_d = 1'b0;
                    if (!k_ok) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        i_d     = 2'd0;
                        j_d     = 2'd0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (xof_ready_i) begin
                    xof_start_o = 1'b1;
                    sn_start_o  = 1'b1;
                    cnt_d       = 8'd0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                s_ready_o   = mem_ready_i;
                mem_we_o    = hs;
                mem_wdata_o = s_data_i[11:0];
                if (sn_done_i) err_d = 1'b1;
                if (hs) begin
                    cnt_d = cnt_q + 8'd1;
                    // The sampler's last flag must line up exactly with coefficient 255.
                    if (s_last_i != cnt_full) err_d = 1'b1;
                    if (s_data_i[11:0] >= 12'(Q)) err_d = 1'b1;
                    if (s_last_i || cnt_full) state_d = S_WAIT_SN;
                end
            end
            S_WAIT_SN: begin
                if (sn_done_i) begin
                    xof_stop_o = 1'b1;
                    if (j_last) begin
                        j_d     = 2'd0;
                        i_d     = i_q + 2'd1;
                        state_d = i_last ? S_DONE : S_ISSUE;
                    end else begin
                        j_d     = j_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
            cnt_q   <= 8'd0;
            k_q     <= 3'd0;
            tr_q    <= 1'b0;
            rho_q   <= 256'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            tr_q    <= tr_d;
            rho_q   <= rho_d;
            err_q   <= err_d;
        end
    end

endmodule
